mips_inst_encoder: RTL and testbench
====================================

# mips_inst_encoder

Instruction-stream encoder for the MIPS superscalar test environment. It accepts symbolic instruction requests (operation select plus register, immediate and target fields) and emits 32-bit MIPS instruction words for the supported ISA subset, tagged with a program counter. It is the producer-side counterpart of the front-end decode, feeding instruction memory images or the fetch stage directly. When enabled, it automatically inserts a NOP delay slot after every control-transfer instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC assigned to the first emitted word after reset.
- `AUTO_DELAY_SLOT`, default 1: 1 = insert a NOP after each control transfer; 0 = never insert.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_op`  in  5  operation select (see Operation).
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  16  immediate or branch offset.
- `in_target`  in  26  jump target field.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_inst`  out  32  encoded instruction word.
- `out_pc`  out  32  PC of `out_inst`.
- `out_slot`  out  1  word is an auto-inserted delay-slot NOP.
- `out_illegal`  out  1  `in_op` was unsupported; `out_inst` = 0.

## Operation
- R-type, `{6'h00, rs, rt, rd, 5'b0, funct}`:
  - 0 ADD (funct 20)
  - 1 ADDU (21)
  - 2 AND (24)
  - 3 NOR (27)
  - 4 OR (25)
  - 5 SUB (22)
  - 6 XOR (26)
- Jump-register forms:
  - 7 JR: `{6'h00, rs, 15'b0, 6'h08}`
  - 8 JALR: `{6'h00, rs, 5'b0, rd, 5'b0, 6'h09}`
- I-type, `{op, rs, rt, imm}`:
  - 9 ADDI (op 08)
  - 10 ANDI (0C)
  - 11 ORI (0D)
  - 12 XORI (0E)
  - 13 BEQ (04)
  - 14 BNE (05)
- Single-source branches, `{op, rs, 5'b0, imm}`: 15 BGTZ (07), 16 BLEZ (06).
- REGIMM branches, `{6'h01, rs, code, imm}`:
  - 17 BGEZ (code 01)
  - 18 BGEZAL (11)
  - 19 BLTZ (00)
  - 20 BLTZAL (10)
- J-type, `{op, target}`: 21 J (02), 22 JAL (03).
- 23 NOP emits 32'h0.
- 24–31 are illegal:
  - emit 32'h0 with `out_illegal` = 1.
  - The word still consumes a PC.
  - It is never followed by a delay slot.
- Control transfers are ops 7, 8 and 13–22.
- Fields not used by the selected op are ignored.
- PC register `next_pc`:
  - resets to `RESET_PC`.
  - every load of the output register copies `next_pc` into `out_pc`, then adds 4, wrapping modulo 2^32.
- FSM states:
  - RUN: `in_ready = !out_valid | out_ready`. An accepted request loads the output register. If the op is a control transfer and `AUTO_DELAY_SLOT` = 1, go to SLOT; otherwise stay in RUN.
  - SLOT: `in_ready` = 0. When the output register frees (`!out_valid | out_ready`), load NOP with `out_slot` = 1 and the next PC, then go to RUN.
- Output register:
  - holds its contents while `out_valid & !out_ready`.
  - `out_valid` clears only on a handshake with no new load in the same cycle.

## Timing
- Reset values:
  - `out_valid` = 0, `out_inst` = 0, `out_pc` = `RESET_PC`
  - `out_slot` = 0, `out_illegal` = 0
  - state = RUN, `next_pc` = `RESET_PC`
  - `in_ready` = 1 in the first cycle after reset.
- Latency: a request accepted at edge N is on `out_*` after edge N, with `out_valid` = 1.
- Throughput: one word per cycle with `out_ready` held high. A control transfer costs one input bubble, the SLOT cycle.
- Simultaneous output handshake and new load in the same cycle: the new word replaces the old one and `out_valid` stays 1.
- `in_ready` depends combinationally on `out_ready`; no other input-to-output combinational path exists.
- Back-pressure in SLOT: the NOP waits until the pending branch word is consumed. No request is accepted meanwhile.
- Reset asserted mid-operation, including in SLOT:
  - the pending word and any pending slot are discarded.
  - the PC returns to `RESET_PC`.
- PC wrap: a word at 32'hFFFF_FFFC is followed by a word at 32'h0000_0000.

## Test plan
- ADDU rs=1 rt=2 rd=3 after reset -> `out_inst` 32'h0022_1821, `out_pc` 0, one cycle after acceptance.
- ADDI rs=0 rt=5 imm=16'h0010, then J target=26'h40, `out_ready` held high -> words 32'h2005_0010 (pc 0), 32'h0800_0040 (pc 4), NOP with `out_slot` = 1 (pc 8); `in_ready` low exactly one cycle.
- BLTZAL rs=4 imm=3 with `out_ready` low for 3 cycles -> 32'h0490_0003 held stable; NOP appears only after the handshake; no new request accepted until then.
- `in_op` = 27 -> `out_inst` 0, `out_illegal` = 1, PC advances by 4, no slot inserted.
- `RESET_PC` = 32'hFFFF_FFFC, `AUTO_DELAY_SLOT` = 0, BEQ rs=1 rt=2 imm=16'hFFFF, then ORI -> 32'h1022_FFFF at pc FFFF_FFFC, ORI at pc 0, no NOP.
- `rst` asserted in SLOT -> `out_valid` = 0, `out_pc` = `RESET_PC`, state RUN; the next request is encoded at `RESET_PC`.

Source files
------------

// File: rtl/mips_inst_encoder_if.sv
// Request/response bundle for the MIPS instruction-stream encoder.
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1. A producer holds valid and its
// payload steady until that edge. A consumer may raise or drop ready at any
// time. The encoder's in_ready may depend combinationally on out_ready.
interface mips_inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_slot;
    logic        out_illegal;

    // Request source and word sink, seen from outside the encoder.
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_slot, out_illegal
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_slot, out_illegal
    );
endinterface

// File: rtl/mips_inst_encoder.sv
// MIPS instruction-stream encoder. Turns symbolic requests into 32-bit
// instruction words tagged with a PC. When enabled, a NOP delay slot is
// inserted after every control transfer.
module mips_inst_encoder #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          AUTO_DELAY_SLOT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_inst_encoder_if.slave    bus,
    output logic                  dbg_state   // 1 while a delay slot is pending
);
    localparam bit USE_SLOT = (AUTO_DELAY_SLOT != 0);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_SLOT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] enc_inst;
    logic        enc_illegal;
    logic        enc_ctrl;
    logic        out_free;
    logic        accept;

    // The output register can take a new word when empty or being drained.
    assign out_free     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == S_RUN) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign dbg_state    = (state == S_SLOT);

    // Encode the current request; unused fields are simply not referenced.
    always_comb begin
        enc_inst    = 32'h0;
        enc_illegal = 1'b0;
        enc_ctrl    = 1'b0;
        case (bus.in_op)
            5'd0:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h20};
            5'd1:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h21};
            5'd2:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h24};
            5'd3:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h27};
            5'd4:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h25};
            5'd5:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h22};
            5'd6:  enc_inst = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h26};
            5'd7: begin
                enc_inst = {6'h00, bus.in_rs, 15'b0, 6'h08};
                enc_ctrl = 1'b1;
            end
            5'd8: begin
                enc_inst = {6'h00, bus.in_rs, 5'b0, bus.in_rd, 5'b0, 6'h09};
                enc_ctrl = 1'b1;
            end
            5'd9:  enc_inst = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd10: enc_inst = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd11: enc_inst = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd12: enc_inst = {6'h0E, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd13: begin
                enc_inst = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd14: begin
                enc_inst = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd15: begin
                enc_inst = {6'h07, bus.in_rs, 5'b0, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd16: begin
                enc_inst = {6'h06, bus.in_rs, 5'b0, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd17: begin
                enc_inst = {6'h01, bus.in_rs, 5'h01, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd18: begin
                enc_inst = {6'h01, bus.in_rs, 5'h11, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd19: begin
                enc_inst = {6'h01, bus.in_rs, 5'h00, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd20: begin
                enc_inst = {6'h01, bus.in_rs, 5'h10, bus.in_imm};
                enc_ctrl = 1'b1;
            end
            5'd21: begin
                enc_inst = {6'h02, bus.in_target};
                enc_ctrl = 1'b1;
            end
            5'd22: begin
                enc_inst = {6'h03, bus.in_target};
                enc_ctrl = 1'b1;
            end
            5'd23:   enc_inst    = 32'h0;
            default: enc_illegal = 1'b1;   // word is 0, no delay slot
        endcase
    end

    // RUN/SLOT sequencer, output register and PC counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_RUN;
            next_pc         <= RESET_PC;
            bus.out_valid   <= 1'b0;
            bus.out_inst    <= 32'h0;
            bus.out_pc      <= RESET_PC;
            bus.out_slot    <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else begin
            // A drained word empties the register unless a load below refills it.
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                S_RUN: begin
                    if (accept) begin
                        bus.out_valid   <= 1'b1;
                        bus.out_inst    <= enc_inst;
                        bus.out_pc      <= next_pc;
                        bus.out_slot    <= 1'b0;
                        bus.out_illegal <= enc_illegal;
                        next_pc         <= next_pc + 32'd4;
                        if (enc_ctrl && USE_SLOT) begin
                            state <= S_SLOT;
                        end
                    end
                end
                S_SLOT: begin
                    if (out_free) begin
                        bus.out_valid   <= 1'b1;
                        bus.out_inst    <= 32'h0;
                        bus.out_pc      <= next_pc;
                        bus.out_slot    <= 1'b1;
                        bus.out_illegal <= 1'b0;
                        next_pc         <= next_pc + 32'd4;
                        state           <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder: directed cases plus randomized traffic with a
// scoreboard fed from a table-driven reference encoder.
module tb_mips_inst_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg0;
    logic dbg1;

    int n_checks = 0;
    int n_fail   = 0;

    mips_inst_encoder_if bus0();
    mips_inst_encoder_if bus1();

    mips_inst_encoder #(.RESET_PC(32'h0000_0000), .AUTO_DELAY_SLOT(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
    );
    mips_inst_encoder #(.RESET_PC(32'hFFFF_FFFC), .AUTO_DELAY_SLOT(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference tables: R-type funct, I-type/branch opcodes (ops 9..16), REGIMM codes.
    logic [5:0] funct_tab [0:6] = '{6'h20, 6'h21, 6'h24, 6'h27, 6'h25, 6'h22, 6'h26};
    logic [5:0] iop_tab   [0:7] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h07, 6'h06};
    logic [4:0] code_tab  [0:3] = '{5'h01, 5'h11, 5'h00, 5'h10};

    // Scoreboard entries: {slot, illegal, pc, inst}.
    logic [65:0] exp_q[$];
    logic [31:0] model_pc = 32'h0;
    bit          rand_ready = 0;

    function automatic void model_encode(input int o, input logic [4:0] rs, rt, rd,
                                         input logic [15:0] imm, input logic [25:0] tgt,
                                         output logic [31:0] inst, output logic ill,
                                         output logic ctl);
        ill  = 1'b0;
        inst = 32'h0;
        ctl  = (o == 7) || (o == 8) || (o >= 13 && o <= 22);
        if (o <= 6)       inst = {6'h00, rs, rt, rd, 5'b0, funct_tab[o]};
        else if (o == 7)  inst = {6'h00, rs, 15'b0, 6'h08};
        else if (o == 8)  inst = {6'h00, rs, 5'b0, rd, 5'b0, 6'h09};
        else if (o <= 14) inst = {iop_tab[o-9], rs, rt, imm};
        else if (o <= 16) inst = {iop_tab[o-9], rs, 5'b0, imm};
        else if (o <= 20) inst = {6'h01, rs, code_tab[o-17], imm};
        else if (o <= 22) inst = {((o == 21) ? 6'h02 : 6'h03), tgt};
        else if (o == 23) inst = 32'h0;
        else              ill  = 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver for dut0: present a request, push the model's words on acceptance.
    // Called and returns at posedge+1.
    task automatic send0(input int op, input logic [4:0] rs, rt, rd,
                         input logic [15:0] imm, input logic [25:0] tgt);
        bit          acc = 0;
        logic [31:0] inst;
        logic        ill, ctl;
        bus0.in_valid  = 1'b1;
        bus0.in_op     = 5'(op);
        bus0.in_rs     = rs;
        bus0.in_rt     = rt;
        bus0.in_rd     = rd;
        bus0.in_imm    = imm;
        bus0.in_target = tgt;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus0.in_ready;
            if (acc) begin
                model_encode(op, rs, rt, rd, imm, tgt, inst, ill, ctl);
                exp_q.push_back({1'b0, ill, model_pc, inst});
                model_pc = model_pc + 32'd4;
                if (ctl && !ill) begin
                    exp_q.push_back({1'b1, 1'b0, model_pc, 32'h0});
                    model_pc = model_pc + 32'd4;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: op %0d never accepted", op);
        end
        bus0.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Random consumer back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus0.out_ready = ($urandom_range(0, 9) < 7);
    end

    // Monitor for dut0: pop on each output handshake; stalled words must hold.
    logic [66:0] held;
    bit          held_v = 0;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                n_checks++;
                if ({bus0.out_valid, bus0.out_slot, bus0.out_illegal, bus0.out_pc, bus0.out_inst} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v%b s%b i%b pc %h inst %h, expected %h",
                             bus0.out_valid, bus0.out_slot, bus0.out_illegal, bus0.out_pc, bus0.out_inst, held);
                end
            end
            held_v = 0;
            if (bus0.out_valid && bus0.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: pc %h inst %h with empty queue", bus0.out_pc, bus0.out_inst);
                end else begin
                    logic [65:0] e;
                    e = exp_q.pop_front();
                    if ({bus0.out_slot, bus0.out_illegal, bus0.out_pc, bus0.out_inst} !== e) begin
                        n_fail++;
                        $display("FAIL word: got s%b i%b pc %h inst %h, expected s%b i%b pc %h inst %h",
                                 bus0.out_slot, bus0.out_illegal, bus0.out_pc, bus0.out_inst,
                                 e[65], e[64], e[63:32], e[31:0]);
                    end
                end
            end else if (bus0.out_valid) begin
                held_v = 1;
                held   = {1'b1, bus0.out_slot, bus0.out_illegal, bus0.out_pc, bus0.out_inst};
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int cnt;
        bit done;
        logic [31:0] inst;
        logic        ill, ctl;

        bus0.in_valid = 0; bus0.in_op = 0; bus0.in_rs = 0; bus0.in_rt = 0; bus0.in_rd = 0;
        bus0.in_imm = 0; bus0.in_target = 0; bus0.out_ready = 1;
        bus1.in_valid = 0; bus1.in_op = 0; bus1.in_rs = 0; bus1.in_rt = 0; bus1.in_rd = 0;
        bus1.in_imm = 0; bus1.in_target = 0; bus1.out_ready = 1;

        // Reset and reset-state checks.
        idle(3);
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_inst", bus0.out_inst, 32'h0);
        chk("rst_out_pc", bus0.out_pc, 32'h0);
        chk("rst_out_slot", 32'(bus0.out_slot), 32'd0);
        chk("rst_out_illegal", 32'(bus0.out_illegal), 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("rst_state", 32'(dbg0), 32'd0);
        chk("rst_pc_dut1", bus1.out_pc, 32'hFFFF_FFFC);

        // ADDU, one-cycle latency.
        send0(1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("addu_valid", 32'(bus0.out_valid), 32'd1);
        chk("addu_inst", bus0.out_inst, 32'h0022_1821);
        chk("addu_pc", bus0.out_pc, 32'h0);

        // ADDI then J back-to-back: exactly one in_ready bubble.
        send0(9, 5'd0, 5'd5, 5'd0, 16'h0010, 26'h0);
        chk("addi_inst", bus0.out_inst, 32'h2005_0010);
        send0(21, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        chk("j_inst", bus0.out_inst, 32'h0800_0040);
        cnt = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (bus0.in_ready) done = 1;
            else cnt++;
            @(posedge clk);
            #1;
        end
        chk("j_bubble_cycles", 32'(cnt), 32'd1);
        idle(2);

        // BLTZAL under 3 cycles of back-pressure.
        bus0.out_ready = 0;
        send0(20, 5'd4, 5'd0, 5'd0, 16'h0003, 26'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bltzal_held_inst", bus0.out_inst, 32'h0490_0003);
            chk("bltzal_held_slot", 32'(bus0.out_slot), 32'd0);
            chk("bltzal_in_ready", 32'(bus0.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus0.out_ready = 1;
        idle(1);
        chk("bltzal_nop_slot", 32'(bus0.out_slot), 32'd1);
        chk("bltzal_nop_inst", bus0.out_inst, 32'h0);
        idle(2);

        // Illegal op: zero word, flagged, consumes a PC, no slot.
        send0(27, 5'd7, 5'd7, 5'd7, 16'hABCD, 26'h3FF_FFFF);
        chk("illegal_flag", 32'(bus0.out_illegal), 32'd1);
        chk("illegal_inst", bus0.out_inst, 32'h0);
        send0(0, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0);
        idle(3);

        // Reset while a delay slot is pending.
        bus0.out_ready = 0;
        send0(22, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123);
        @(negedge clk);
        chk("slot_state_before_rst", 32'(dbg0), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        model_pc = 32'h0;
        chk("rst_slot_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_slot_out_pc", bus0.out_pc, 32'h0);
        chk("rst_slot_state", 32'(dbg0), 32'd0);
        bus0.out_ready = 1;
        send0(4, 5'd1, 5'd1, 5'd2, 16'h0, 26'h0);
        chk("after_rst_pc", bus0.out_pc, 32'h0);
        idle(2);

        // Randomized traffic with random back-pressure.
        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send0($urandom_range(0, 31), 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), 26'($urandom));
        end
        rand_ready = 0;
        bus0.out_ready = 1;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            idle(1);
            if (exp_q.size() == 0 && !bus0.out_valid) done = 1;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // dut1: PC wrap, no delay slot.
        bus1.in_valid = 1; bus1.in_op = 5'd13; bus1.in_rs = 5'd1; bus1.in_rt = 5'd2;
        bus1.in_imm = 16'hFFFF;
        @(negedge clk);
        chk("wrap_beq_ready", 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_beq_inst", bus1.out_inst, 32'h1022_FFFF);
        chk("wrap_beq_pc", bus1.out_pc, 32'hFFFF_FFFC);
        bus1.in_op = 5'd11; bus1.in_rs = 5'd3; bus1.in_rt = 5'd4; bus1.in_imm = 16'h1234;
        model_encode(11, 5'd3, 5'd4, 5'd0, 16'h1234, 26'h0, inst, ill, ctl);
        @(negedge clk);
        chk("wrap_no_slot_ready", 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 0;
        chk("wrap_ori_inst", bus1.out_inst, inst);
        chk("wrap_ori_pc", bus1.out_pc, 32'h0);
        chk("wrap_ori_slot", 32'(bus1.out_slot), 32'd0);
        idle(1);
        chk("wrap_no_nop", 32'(bus1.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
